// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback,
// drives the datapath selects and strobes, counts retired instructions and traps on illegal opcodes or stalled memory.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic             branch_taken_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             ir_write_enable_o,
    output logic             pc_write_enable_o,
    output logic             reg_write_enable_o,
    output logic             alu_src_1_o,
    output logic [1:0]       alu_src_2_o,
    output logic [1:0]       reg_write_src_o,
    output logic [1:0]       pc_src_o,
    output logic [2:0]       state_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             illegal_o,
    output logic             timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP
    } op_class_t;

    localparam bit WDOG_ON = (TIMEOUT_CYCLES > 0);
    localparam int WAIT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state;
    op_class_t         op_class;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  instret;
    logic              illegal;
    logic              timeout;
    logic              wdog_fire;

    // Anything not matched here stays C_NONE and is trapped as illegal in DECODE.
    always_comb begin
        op_class = C_NONE;
        case (opcode_i)
            7'b0110111: op_class = C_LUI;
            7'b0010111: op_class = C_AUIPC;
            7'b1101111: op_class = C_JAL;
            7'b1100111: if (funct3_i == 3'b000) op_class = C_JALR;
            7'b1100011: if (funct3_i != 3'b010 && funct3_i != 3'b011) op_class = C_BRANCH;
            7'b0000011: if (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) op_class = C_LOAD;
            7'b0100011: if (funct3_i inside {3'b000, 3'b001, 3'b010}) op_class = C_STORE;
            7'b0010011: op_class = C_OPIMM;
            7'b0110011: if (funct7_i == 7'b0000000 || funct7_i == 7'b0100000) op_class = C_OP;
            default: op_class = C_NONE;
        endcase
    end

    // A completing request takes priority over the watchdog firing in the same cycle.
    assign wdog_fire = WDOG_ON && !mem_ready_i && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            instret  <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH, S_MEMORY: begin
                    if (mem_ready_i) begin
                        wait_cnt <= '0;
                        if (state == S_FETCH)
                            state <= S_DECODE;
                        else if (op_class == C_STORE)
                            state <= S_FETCH;
                        else
                            state <= S_WRITEBACK;
                    end else if (wdog_fire) begin
                        wait_cnt <= '0;
                        timeout  <= 1'b1;
                        state    <= S_TRAP;
                    end else if (WDOG_ON) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (op_class == C_NONE) begin
                        illegal <= 1'b1;
                        state   <= S_TRAP;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE:   state <= (op_class == C_LOAD || op_class == C_STORE) ? S_MEMORY : S_WRITEBACK;
                S_WRITEBACK: state <= S_FETCH;
                default:     state <= S_TRAP;
            endcase
            if (retire_o)
                instret <= instret + 1'b1;
        end
    end

    always_comb begin
        mem_req_o          = 1'b0;
        mem_we_o           = 1'b0;
        ir_write_enable_o  = 1'b0;
        pc_write_enable_o  = 1'b0;
        reg_write_enable_o = 1'b0;
        alu_src_1_o        = 1'b0;
        alu_src_2_o        = 2'b00;
        reg_write_src_o    = 2'b00;
        pc_src_o           = 2'b00;
        retire_o           = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_o         = 1'b1;
                ir_write_enable_o = mem_ready_i;
            end
            S_EXECUTE: begin
                case (op_class)
                    C_LUI:            alu_src_2_o = 2'b10;
                    C_AUIPC:          begin alu_src_1_o = 1'b1; alu_src_2_o = 2'b10; end
                    C_STORE:          alu_src_2_o = 2'b01;
                    C_OP, C_BRANCH:   alu_src_2_o = 2'b11;
                    default:          alu_src_2_o = 2'b00;
                endcase
            end
            S_MEMORY: begin
                mem_req_o = 1'b1;
                mem_we_o  = (op_class == C_STORE);
                if (op_class == C_STORE && mem_ready_i) begin
                    pc_write_enable_o = 1'b1;
                    retire_o          = 1'b1;
                end
            end
            S_WRITEBACK: begin
                pc_write_enable_o  = 1'b1;
                retire_o           = 1'b1;
                reg_write_enable_o = (op_class != C_BRANCH);
                case (op_class)
                    C_AUIPC, C_OP, C_OPIMM: reg_write_src_o = 2'b01;
                    C_LOAD:                 reg_write_src_o = 2'b10;
                    C_JAL, C_JALR:          reg_write_src_o = 2'b11;
                    default:                reg_write_src_o = 2'b00;
                endcase
                case (op_class)
                    C_JAL:    pc_src_o = 2'b01;
                    C_JALR:   pc_src_o = 2'b10;
                    C_BRANCH: pc_src_o = branch_taken_i ? 2'b01 : 2'b00;
                    default:  pc_src_o = 2'b00;
                endcase
            end
            default: ;
        endcase
    end

    assign state_o   = state;
    assign instret_o = instret;
    assign illegal_o = illegal;
    assign timeout_o = timeout;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues the expected per-cycle output vector,
// a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq;
        logic       mwe;
        logic       irwe;
        logic       pcwe;
        logic       rwe;
        logic       s1;
        logic [1:0] s2;
        logic [1:0] rws;
        logic [1:0] pcs;
        logic       ret;
        logic       ill;
        logic       tmo;
        logic [3:0] cnt;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, ir_we, pc_we, reg_we, src1, retire, illegal, timeout;
    logic [1:0] src2, rws, pcs;
    logic [2:0] state;
    logic [3:0] instret;

    rec_t       exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;
    logic [3:0] n = 4'd0;

    multicycle_control #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .branch_taken_i(branch_taken), .mem_ready_i(mem_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we),
        .ir_write_enable_o(ir_we), .pc_write_enable_o(pc_we), .reg_write_enable_o(reg_we),
        .alu_src_1_o(src1), .alu_src_2_o(src2), .reg_write_src_o(rws), .pc_src_o(pcs),
        .state_o(state), .retire_o(retire), .instret_o(instret),
        .illegal_o(illegal), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input logic [2:0] st, input logic mreq, input logic mwe, input logic irwe,
                                input logic pcwe, input logic rwe, input logic s1, input logic [1:0] s2,
                                input logic [1:0] rs, input logic [1:0] ps, input logic ret,
                                input logic ill, input logic tmo, input logic [3:0] c);
        rec_t r;
        r = '{st: st, mreq: mreq, mwe: mwe, irwe: irwe, pcwe: pcwe, rwe: rwe, s1: s1, s2: s2,
              rws: rs, pcs: ps, ret: ret, ill: ill, tmo: tmo, cnt: c};
        return r;
    endfunction

    function automatic rec_t f_idle(input logic [3:0] c);
        return mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic rec_t f_fetch(input logic r, input logic [3:0] c);
        return mk(3'd1, 1'b1, 1'b0, r, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic rec_t f_dec(input logic [3:0] c);
        return mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic rec_t f_exe(input logic s1, input logic [1:0] s2, input logic [3:0] c);
        return mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s1, s2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic rec_t f_mem(input logic we, input logic done, input logic [3:0] c);
        return mk(3'd4, 1'b1, we, 1'b0, done, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, done, 1'b0, 1'b0, c);
    endfunction
    function automatic rec_t f_wb(input logic rwe, input logic [1:0] rs, input logic [1:0] ps, input logic [3:0] c);
        return mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, rwe, 1'b0, 2'b00, rs, ps, 1'b1, 1'b0, 1'b0, c);
    endfunction
    function automatic rec_t f_trap(input logic ill, input logic tmo, input logic [3:0] c);
        return mk(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, ill, tmo, c);
    endfunction

    // One clock cycle: drive inputs, queue what the DUT must show in this cycle.
    task automatic cyc(input logic rdy, input logic tk, input rec_t e, input string nm);
        mem_ready    = rdy;
        branch_taken = tk;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        n   = 4'd0;
        cyc(1'b1, 1'b0, f_idle(4'd0), "reset_state");
        rst = 1'b0;
        cyc(1'b1, 1'b0, f_idle(4'd0), "idle_after_reset");
    endtask

    // Non-memory instruction with memory always ready.
    task automatic run_simple(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic s1, input logic [1:0] s2, input logic rwe, input logic [1:0] rs,
                              input logic [1:0] ps, input logic tk);
        instr(op, f3, f7);
        cyc(1'b1, 1'b0, f_fetch(1'b1, n), {nm, "_fetch"});
        cyc(1'b1, 1'b0, f_dec(n), {nm, "_decode"});
        cyc(1'b1, 1'b0, f_exe(s1, s2, n), {nm, "_execute"});
        cyc(1'b1, tk, f_wb(rwe, rs, ps, n), {nm, "_writeback"});
        n = n + 4'd1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            rec_t  act;
            rec_t  e;
            string nm;
            act = {state, mem_req, mem_we, ir_we, pc_we, reg_we, src1, src2, rws, pcs,
                   retire, illegal, timeout, instret};
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_cycle: actual=%h required=<no entry>", act);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("FAIL %s: actual=%h required=%h", nm, act, e);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset();

        run_simple("addi", 7'b0010011, 3'b000, 7'd0, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0);

        // LW with memory stalled 3 cycles
        instr(7'b0000011, 3'b010, 7'd0);
        cyc(1'b1, 1'b0, f_fetch(1'b1, n), "lw_fetch");
        cyc(1'b1, 1'b0, f_dec(n), "lw_decode");
        cyc(1'b1, 1'b0, f_exe(1'b0, 2'b00, n), "lw_execute");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, f_mem(1'b0, 1'b0, n), "lw_mem_wait");
        cyc(1'b1, 1'b0, f_mem(1'b0, 1'b0, n), "lw_mem_done");
        cyc(1'b1, 1'b0, f_wb(1'b1, 2'b10, 2'b00, n), "lw_writeback");
        n = n + 4'd1;

        // SW with one fetch stall
        instr(7'b0100011, 3'b010, 7'd0);
        cyc(1'b0, 1'b0, f_fetch(1'b0, n), "sw_fetch_wait");
        cyc(1'b1, 1'b0, f_fetch(1'b1, n), "sw_fetch");
        cyc(1'b1, 1'b0, f_dec(n), "sw_decode");
        cyc(1'b1, 1'b0, f_exe(1'b0, 2'b01, n), "sw_execute");
        cyc(1'b1, 1'b0, f_mem(1'b1, 1'b1, n), "sw_mem_retire");
        n = n + 4'd1;

        run_simple("beq_taken", 7'b1100011, 3'b000, 7'd0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1);
        run_simple("bne_not_taken", 7'b1100011, 3'b001, 7'd0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
        run_simple("jalr", 7'b1100111, 3'b000, 7'd0, 1'b0, 2'b00, 1'b1, 2'b11, 2'b10, 1'b0);
        run_simple("jal", 7'b1101111, 3'b101, 7'd0, 1'b0, 2'b00, 1'b1, 2'b11, 2'b01, 1'b0);
        run_simple("lui", 7'b0110111, 3'b000, 7'd0, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0);
        run_simple("auipc", 7'b0010111, 3'b000, 7'd0, 1'b1, 2'b10, 1'b1, 2'b01, 2'b00, 1'b0);
        run_simple("sub", 7'b0110011, 3'b000, 7'b0100000, 1'b0, 2'b11, 1'b1, 2'b01, 2'b00, 1'b0);

        // Illegal opcode: sticky trap until reset, which aborts without a retire
        instr(7'b1111111, 3'b000, 7'd0);
        cyc(1'b1, 1'b0, f_fetch(1'b1, n), "ill_fetch");
        cyc(1'b1, 1'b0, f_dec(n), "ill_decode");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, f_trap(1'b1, 1'b0, n), "ill_trap_hold");
        do_reset();

        // OP with funct7 outside the base set
        instr(7'b0110011, 3'b000, 7'b0000001);
        cyc(1'b1, 1'b0, f_fetch(1'b1, n), "mul_fetch");
        cyc(1'b1, 1'b0, f_dec(n), "mul_decode");
        cyc(1'b1, 1'b0, f_trap(1'b1, 1'b0, n), "mul_trap");
        do_reset();

        // Fetch watchdog expiry
        instr(7'b0010011, 3'b000, 7'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, f_fetch(1'b0, n), "tmo_fetch_wait");
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, f_trap(1'b0, 1'b1, n), "tmo_trap_hold");
        do_reset();

        // Ready on the limit cycle wins over the watchdog
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, f_fetch(1'b0, n), "edge_fetch_wait");
        cyc(1'b1, 1'b0, f_fetch(1'b1, n), "edge_fetch_done");
        cyc(1'b1, 1'b0, f_dec(n), "edge_decode");
        cyc(1'b1, 1'b0, f_exe(1'b0, 2'b00, n), "edge_execute");
        cyc(1'b1, 1'b0, f_wb(1'b1, 2'b01, 2'b00, n), "edge_writeback");
        n = n + 4'd1;

        // 15 more retires take the 4-bit counter through its wrap
        for (int i = 0; i < 15; i++)
            run_simple("wrap_addi", 7'b0010011, 3'b000, 7'd0, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0);
        cyc(1'b0, 1'b0, f_fetch(1'b0, n), "wrap_instret_zero");

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: actual=%0d entries left required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
